pc_unit: RTL
============

Name: pc_unit

Overview:
- Sequential program-counter unit for the LEGv8 single-cycle processor; successor to the combinational PC next-address logic.
- Holds the PC register and computes the next fetch address from sequential, conditional-branch, unconditional-branch, register-indirect and return sources.
- Adds stall hold and a parametrised return-address stack (RAS) for BL/RET.
- Sits between the control unit / register file and instruction memory.

Parameters:
- ADDR_W, 64, PC and target width in bits (>= 28).
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, RAS entries (power of 2, >= 2).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- stall  in  1  hold PC and RAS unchanged this cycle.
- instruction  in  32  current instruction; cond imm = [23:5], uncond imm = [25:0].
- UncondBr  in  1  1 selects the 26-bit imm, 0 selects the 19-bit imm.
- BrTaken  in  1  take the PC-relative branch.
- RegBr  in  1  branch to reg_target (BR).
- Link  in  1  push pc+4 onto RAS (BL/BLR).
- Ret  in  1  return: pop RAS for target.
- reg_target  in  ADDR_W  register-file target for BR/RET fallback.
- pc  out  ADDR_W  current PC (registered).
- pc_plus4  out  ADDR_W  pc+4, combinational; link value to register file.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- misalign  out  1  registered; set when the last accepted register target had bits [1:0] != 0.

Behaviour:
- Reset: pc=RESET_PC, RAS count=0, top pointer=0, misalign=0. Entries are not cleared. Reset overrides stall and every other input.
- Arithmetic: all sums are modulo 2^ADDR_W and wrap silently.
- Branch offset: sign-extend the selected imm to ADDR_W, then shift left 2. br_target = pc + offset.
- Next-PC priority when not stalled (first match wins):
  1. Ret with RAS non-empty: pc <= popped entry.
  2. Ret with RAS empty: pc <= reg_target with [1:0] forced to 0.
  3. RegBr: pc <= reg_target with [1:0] forced to 0.
  4. BrTaken: pc <= br_target.
  5. Otherwise: pc <= pc+4.
- misalign: updated only on cases 2/3, to (reg_target[1:0] != 0). Holds otherwise.
- stall=1: pc, RAS, count and misalign all hold. Link and Ret are ignored.
- RAS is a circular buffer with pointer and count; latency 1 cycle.
  - Push (Link, not Ret): write pc+4 at top+1; count = min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop (Ret, not Link, count>0): read top; pointer decrements; count-1.
  - Ret and Link together (count>0): next pc = popped entry; top entry is replaced by pc+4; count unchanged.
  - Ret and Link with count==0: push only; pc <= reg_target (case 2).
- Link has no effect on next-PC selection; the caller also asserts BrTaken/RegBr as needed.
- pc_plus4 is valid in the same cycle as pc.

Test Plan:
- Reset: assert reset 2 cycles with RESET_PC=0x100 -> pc=0x100, ras_empty=1, misalign=0. Then 3 idle cycles -> pc=0x104, 0x108, 0x10C.
- Branches from pc=0x1000:
  - BrTaken=1, UncondBr=0, imm19=-4 -> pc=0x0FF0.
  - UncondBr=1, imm26=0x0000010 -> pc=0x1040.
  - imm26 negative from pc=0x10 with offset -0x20 -> pc wraps to 0xFFFF_FFFF_FFFF_FFF0.
- Stall: stall=1 for 3 cycles with BrTaken=1, Link=1 -> pc and RAS count unchanged. Releasing stall resumes from the held pc.
- RAS overflow (RAS_DEPTH=4): 5 BL pushes from pcs 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_full=1. 4 Rets return 0x44, 0x34, 0x24, 0x14 -> ras_empty=1. A 5th Ret with reg_target=0x203 -> pc=0x200, misalign=1.
- Simultaneous Link+Ret with count=2 -> pc = old top, count stays 2. The next Ret returns the prior pc+4.
- Mid-operation reset: reset asserted together with Ret and count=3 -> pc=RESET_PC, ras_empty=1. The next Ret uses reg_target.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the LEGv8 single-cycle core: PC register, next-address
// selection (sequential / PC-relative / register / return), stall hold and a return-address stack.
module pc_unit #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       instruction,
  input  logic              UncondBr,
  input  logic              BrTaken,
  input  logic              RegBr,
  input  logic              Link,
  input  logic              Ret,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign
);

  localparam int PW    = $clog2(RAS_DEPTH);
  localparam int CNT_W = PW + 1;

  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]     top;
  logic [CNT_W-1:0]  cnt;

  logic              pop;
  logic              reg_sel;
  logic              replace_top;
  logic [PW-1:0]     wr_idx;
  logic [ADDR_W-1:0] pc_next;
  logic              unused_instr;

  // Branch offset in bytes: sign-extended word immediate scaled by 4.
  function automatic logic signed [ADDR_W-1:0] br_offset(input logic [31:0] ins,
                                                         input logic        uncond);
    logic signed [ADDR_W-1:0] off;
    if (uncond) off = {{(ADDR_W-26){ins[25]}}, ins[25:0]};
    else        off = {{(ADDR_W-19){ins[23]}}, ins[23:5]};
    return off <<< 2;
  endfunction

  assign unused_instr = ^{instruction[31:26], instruction[4:0]};

  assign pc_plus4  = pc + ADDR_W'(4);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CNT_W'(RAS_DEPTH));

  assign pop         = Ret && !ras_empty;
  assign reg_sel     = !pop && (Ret || RegBr);
  // Link+Ret with a live entry swaps the top in place instead of pop-then-push.
  assign replace_top = Link && pop;
  assign wr_idx      = replace_top ? top : top + PW'(1);

  always_comb begin
    pc_next = pc_plus4;
    if (pop)          pc_next = ras[top];
    else if (reg_sel) pc_next = {reg_target[ADDR_W-1:2], 2'b00};
    else if (BrTaken) pc_next = pc + $unsigned(br_offset(instruction, UncondBr));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      top      <= '0;
      cnt      <= '0;
      misalign <= 1'b0;
    end else if (!stall) begin
      pc <= pc_next;
      if (reg_sel) misalign <= |reg_target[1:0];
      if (replace_top) begin
        top <= top;
        cnt <= cnt;
      end else if (Link) begin
        top <= top + PW'(1);
        if (!ras_full) cnt <= cnt + CNT_W'(1);
      end else if (pop) begin
        top <= top - PW'(1);
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Stack storage carries no reset; stale entries are unreachable once count drops.
  always_ff @(posedge clk) begin
    if (!reset && !stall && Link) ras[wr_idx] <= pc_plus4;
  end

endmodule
